// File: rtl/riscv_pkg.sv
// Shared definitions for the memory arbiter: owner encoding, owner FIFO default
// depth and the request payload presented to the AXI driver.
package riscv_pkg;

    localparam int unsigned OWNER_DEPTH_DEFAULT = 16;
    localparam int unsigned XLEN                = 32;

    typedef enum logic {
        OWNER_IFU = 1'b0,
        OWNER_LSU = 1'b1
    } owner_e;

    typedef struct packed {
        logic            rnw;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
    } mem_req_t;

endpackage

// File: rtl/riscv_owner_fifo.sv
// 1-bit owner FIFO: records which requester issued each outstanding read so
// in-order responses can be steered back. Pointers carry one extra wrap bit.
module riscv_owner_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic push_i,
    input  logic pop_i,
    input  logic din_i,
    output logic head_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0] mem_q, mem_d;

    // Status flags, head and pointer/storage next-state
    always_comb begin
        full_o   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        empty_o  = (wr_ptr_q == rd_ptr_q);
        head_o   = mem_q[rd_ptr_q[AW-1:0]];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push_i && !full_o) begin
            mem_d[wr_ptr_q[AW-1:0]] = din_i;
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end
        if (pop_i && !empty_o) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // Pointer and storage registers
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter in front of a single AXI driver
// request port, with grant lock and in-order response steering.
// Build option: define RISCV_MEM_ARB_ROUND_ROBIN_EN to alternate grants on
// conflict; otherwise the load/store unit always wins a conflict.
module riscv_mem_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned OWNER_DEPTH = OWNER_DEPTH_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ifu_req_vld,
    input  logic [31:0] ifu_req_addr,
    output logic        ifu_req_ack,
    input  logic        lsu_req_vld,
    input  logic        lsu_req_rnw,
    input  logic [31:0] lsu_req_addr,
    input  logic [31:0] lsu_req_data,
    output logic        lsu_req_ack,
    output logic        ifu_rsp_vld,
    output logic [31:0] ifu_rsp_addr,
    output logic [31:0] ifu_rsp_data,
    output logic        lsu_rsp_vld,
    output logic [31:0] lsu_rsp_addr,
    output logic [31:0] lsu_rsp_data,
    output logic        mem_req_vld,
    output logic        mem_req_rnw,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_data,
    input  logic        mem_req_ack,
    input  logic        mem_rsp_vld,
    input  logic [31:0] mem_rsp_addr,
    input  logic [31:0] mem_rsp_data,
    output logic        rsp_orphan
);

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_LOCK_IFU = 2'd1,
        ARB_LOCK_LSU = 2'd2
    } arb_state_e;

    arb_state_e state_q, state_d;
    logic       ifu_elig, lsu_elig;
    logic       gnt_vld;
    owner_e     gnt_owner;
    owner_e     conflict_winner;
    mem_req_t   req;
    logic       push, pop;
    logic       fifo_head, fifo_full, fifo_empty;
    logic       orphan_q, orphan_d;

`ifdef RISCV_MEM_ARB_ROUND_ROBIN_EN
    owner_e last_grant_q, last_grant_d;

    // Conflict goes to whoever did not win the last accepted request
    always_comb begin
        conflict_winner = (last_grant_q == OWNER_LSU) ? OWNER_IFU : OWNER_LSU;
        last_grant_d    = (gnt_vld && mem_req_ack) ? gnt_owner : last_grant_q;
    end

    // Last-grant register
    always_ff @(posedge clock) begin
        if (reset) last_grant_q <= OWNER_LSU;
        else       last_grant_q <= last_grant_d;
    end
`else
    // Fixed priority: load/store wins every conflict
    always_comb begin
        conflict_winner = OWNER_LSU;
    end
`endif

    // Eligibility: reads are held back while the owner FIFO is full
    always_comb begin
        ifu_elig = ifu_req_vld & ~fifo_full;
        lsu_elig = lsu_req_vld & (~lsu_req_rnw | ~fifo_full);
    end

    // Grant selection and lock next-state
    always_comb begin
        state_d   = state_q;
        gnt_vld   = 1'b0;
        gnt_owner = OWNER_LSU;
        unique case (state_q)
            ARB_LOCK_IFU: if (ifu_elig) begin
                gnt_vld   = 1'b1;
                gnt_owner = OWNER_IFU;
            end
            ARB_LOCK_LSU: if (lsu_elig) begin
                gnt_vld   = 1'b1;
                gnt_owner = OWNER_LSU;
            end
            default: ;
        endcase
        // An ineligible lock holder releases the lock and normal arbitration applies
        if (!gnt_vld) begin
            if (ifu_elig && lsu_elig) begin
                gnt_vld   = 1'b1;
                gnt_owner = conflict_winner;
            end else if (ifu_elig) begin
                gnt_vld   = 1'b1;
                gnt_owner = OWNER_IFU;
            end else if (lsu_elig) begin
                gnt_vld   = 1'b1;
                gnt_owner = OWNER_LSU;
            end
        end
        if (reset) gnt_vld = 1'b0;
        if (gnt_vld && !mem_req_ack) begin
            state_d = (gnt_owner == OWNER_IFU) ? ARB_LOCK_IFU : ARB_LOCK_LSU;
        end else begin
            state_d = ARB_IDLE;
        end
    end

    // Lock state register
    always_ff @(posedge clock) begin
        if (reset) state_q <= ARB_IDLE;
        else       state_q <= state_d;
    end

    // Request mux, ack routing and response steering
    always_comb begin
        req.rnw  = 1'b1;
        req.addr = ifu_req_addr;
        req.data = '0;
        if (gnt_owner == OWNER_LSU) begin
            req.rnw  = lsu_req_rnw;
            req.addr = lsu_req_addr;
            req.data = lsu_req_data;
        end
        mem_req_vld  = gnt_vld;
        mem_req_rnw  = req.rnw;
        mem_req_addr = req.addr;
        mem_req_data = req.data;
        ifu_req_ack  = gnt_vld & mem_req_ack & (gnt_owner == OWNER_IFU);
        lsu_req_ack  = gnt_vld & mem_req_ack & (gnt_owner == OWNER_LSU);
        push         = gnt_vld & req.rnw & mem_req_ack;
        pop          = mem_rsp_vld & ~fifo_empty & ~reset;
        ifu_rsp_vld  = pop & (owner_e'(fifo_head) == OWNER_IFU);
        lsu_rsp_vld  = pop & (owner_e'(fifo_head) == OWNER_LSU);
        ifu_rsp_addr = mem_rsp_addr;
        ifu_rsp_data = mem_rsp_data;
        lsu_rsp_addr = mem_rsp_addr;
        lsu_rsp_data = mem_rsp_data;
        orphan_d     = orphan_q | (mem_rsp_vld & fifo_empty & ~reset);
        rsp_orphan   = orphan_q;
    end

    // Sticky orphan-response flag
    always_ff @(posedge clock) begin
        if (reset) orphan_q <= 1'b0;
        else       orphan_q <= orphan_d;
    end

    riscv_owner_fifo #(
        .DEPTH (OWNER_DEPTH)
    ) u_owner_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (logic'(gnt_owner)),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter: a queue-based reference model
// checked every cycle, plus literal expectations on directed scenarios.
module tb_riscv_mem_arbiter;

    localparam int unsigned DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_req_vld, ifu_req_ack;
    logic [31:0] ifu_req_addr;
    logic        lsu_req_vld, lsu_req_rnw, lsu_req_ack;
    logic [31:0] lsu_req_addr, lsu_req_data;
    logic        ifu_rsp_vld, lsu_rsp_vld;
    logic [31:0] ifu_rsp_addr, ifu_rsp_data, lsu_rsp_addr, lsu_rsp_data;
    logic        mem_req_vld, mem_req_rnw, mem_req_ack;
    logic [31:0] mem_req_addr, mem_req_data;
    logic        mem_rsp_vld;
    logic [31:0] mem_rsp_addr, mem_rsp_data;
    logic        rsp_orphan;

    int n_chk  = 0;
    int n_fail = 0;

    riscv_mem_arbiter #(.OWNER_DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .ifu_req_vld  (ifu_req_vld),
        .ifu_req_addr (ifu_req_addr),
        .ifu_req_ack  (ifu_req_ack),
        .lsu_req_vld  (lsu_req_vld),
        .lsu_req_rnw  (lsu_req_rnw),
        .lsu_req_addr (lsu_req_addr),
        .lsu_req_data (lsu_req_data),
        .lsu_req_ack  (lsu_req_ack),
        .ifu_rsp_vld  (ifu_rsp_vld),
        .ifu_rsp_addr (ifu_rsp_addr),
        .ifu_rsp_data (ifu_rsp_data),
        .lsu_rsp_vld  (lsu_rsp_vld),
        .lsu_rsp_addr (lsu_rsp_addr),
        .lsu_rsp_data (lsu_rsp_data),
        .mem_req_vld  (mem_req_vld),
        .mem_req_rnw  (mem_req_rnw),
        .mem_req_addr (mem_req_addr),
        .mem_req_data (mem_req_data),
        .mem_req_ack  (mem_req_ack),
        .mem_rsp_vld  (mem_rsp_vld),
        .mem_rsp_addr (mem_rsp_addr),
        .mem_rsp_data (mem_rsp_data),
        .rsp_orphan   (rsp_orphan)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owners of outstanding reads as a queue, lock holder,
    // last winner (0=IFU, 1=LSU) and the sticky orphan bit.
    int unsigned own_q[$];
    int          lock_m   = -1;
    int          last_m   = 1;
    bit          orphan_m = 1'b0;

    always @(negedge clock) begin : model_cmp
        bit full_m, ifu_ok, lsu_ok, pop_m, acc;
        int sel, hd;
        full_m = (own_q.size() == DEPTH);
        ifu_ok = ifu_req_vld && !full_m;
        lsu_ok = lsu_req_vld && (!lsu_req_rnw || !full_m);
        if (reset) sel = -1;
        else if (lock_m == 0 && ifu_ok) sel = 0;
        else if (lock_m == 1 && lsu_ok) sel = 1;
        else if (ifu_ok && lsu_ok) begin
`ifdef RISCV_MEM_ARB_ROUND_ROBIN_EN
            sel = (last_m == 1) ? 0 : 1;
`else
            sel = 1;
`endif
        end
        else if (ifu_ok) sel = 0;
        else if (lsu_ok) sel = 1;
        else sel = -1;

        acc   = (sel >= 0) && mem_req_ack;
        pop_m = !reset && mem_rsp_vld && (own_q.size() > 0);
        hd    = pop_m ? int'(own_q[0]) : -1;

        check("m_mem_req_vld", 32'(mem_req_vld), 32'(sel >= 0));
        if (sel == 0) begin
            check("m_mem_req_rnw", 32'(mem_req_rnw), 32'd1);
            check("m_mem_req_addr", mem_req_addr, ifu_req_addr);
        end else if (sel == 1) begin
            check("m_mem_req_rnw", 32'(mem_req_rnw), 32'(lsu_req_rnw));
            check("m_mem_req_addr", mem_req_addr, lsu_req_addr);
            if (!lsu_req_rnw) check("m_mem_req_data", mem_req_data, lsu_req_data);
        end
        check("m_ifu_req_ack", 32'(ifu_req_ack), 32'(acc && sel == 0));
        check("m_lsu_req_ack", 32'(lsu_req_ack), 32'(acc && sel == 1));
        check("m_ifu_rsp_vld", 32'(ifu_rsp_vld), 32'(hd == 0));
        check("m_lsu_rsp_vld", 32'(lsu_rsp_vld), 32'(hd == 1));
        if (hd == 0) check("m_ifu_rsp_data", ifu_rsp_data, mem_rsp_data);
        if (hd == 1) check("m_lsu_rsp_data", lsu_rsp_data, mem_rsp_data);
        check("m_rsp_orphan", 32'(rsp_orphan), 32'(orphan_m));

        if (reset) begin
            own_q.delete();
            lock_m   = -1;
            last_m   = 1;
            orphan_m = 1'b0;
        end else begin
            if (mem_rsp_vld && own_q.size() == 0) orphan_m = 1'b1;
            if (pop_m) void'(own_q.pop_front());
            if (acc && (sel == 0 || lsu_req_rnw)) own_q.push_back(sel);
            if (acc) last_m = sel;
            lock_m = ((sel >= 0) && !mem_req_ack) ? sel : -1;
        end
    end

    // Advance to just after the next rising edge and clear all inputs
    task automatic step();
        @(posedge clock);
        #1;
        reset        = 1'b0;
        ifu_req_vld  = 1'b0;
        ifu_req_addr = '0;
        lsu_req_vld  = 1'b0;
        lsu_req_rnw  = 1'b0;
        lsu_req_addr = '0;
        lsu_req_data = '0;
        mem_req_ack  = 1'b0;
        mem_rsp_vld  = 1'b0;
        mem_rsp_addr = '0;
        mem_rsp_data = '0;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    logic [31:0] exp_addr [4];
    logic        exp_own  [6];

    initial begin
        reset = 1'b1;
        ifu_req_vld = 1'b0; ifu_req_addr = '0;
        lsu_req_vld = 1'b0; lsu_req_rnw = 1'b0; lsu_req_addr = '0; lsu_req_data = '0;
        mem_req_ack = 1'b0; mem_rsp_vld = 1'b0; mem_rsp_addr = '0; mem_rsp_data = '0;

        // Reset cycle with live inputs: no acks, no responses
        step(); reset = 1'b1;
        ifu_req_vld = 1'b1; ifu_req_addr = 32'h100; mem_req_ack = 1'b1;
        mem_rsp_vld = 1'b1; mem_rsp_data = 32'h1234;
        settle();
        check("rst_ifu_ack", 32'(ifu_req_ack), 32'd0);
        check("rst_ifu_rsp_vld", 32'(ifu_rsp_vld), 32'd0);
        check("rst_lsu_rsp_vld", 32'(lsu_rsp_vld), 32'd0);
        step();
        settle();
        check("rst_orphan", 32'(rsp_orphan), 32'd0);

        // Lone fetch read, then its response
        step(); ifu_req_vld = 1'b1; ifu_req_addr = 32'h100; mem_req_ack = 1'b1;
        settle();
        check("ifu_alone_ack", 32'(ifu_req_ack), 32'd1);
        check("ifu_alone_addr", mem_req_addr, 32'h100);
        step();
        settle();
        step(); mem_rsp_vld = 1'b1; mem_rsp_addr = 32'h100; mem_rsp_data = 32'hDEADBEEF;
        settle();
        check("ifu_rsp_vld", 32'(ifu_rsp_vld), 32'd1);
        check("ifu_rsp_data", ifu_rsp_data, 32'hDEADBEEF);
        check("ifu_rsp_lsu_vld", 32'(lsu_rsp_vld), 32'd0);

        // Four cycles of simultaneous reads, always acked
`ifdef RISCV_MEM_ARB_ROUND_ROBIN_EN
        exp_addr[0] = 32'h2000; exp_addr[1] = 32'h1004; exp_addr[2] = 32'h2008; exp_addr[3] = 32'h100C;
`else
        exp_addr[0] = 32'h2000; exp_addr[1] = 32'h2004; exp_addr[2] = 32'h2008; exp_addr[3] = 32'h200C;
`endif
        for (int i = 0; i < 4; i++) begin
            step();
            ifu_req_vld = 1'b1; ifu_req_addr = 32'h1000 + 32'(i * 4);
            lsu_req_vld = 1'b1; lsu_req_rnw = 1'b1; lsu_req_addr = 32'h2000 + 32'(i * 4);
            mem_req_ack = 1'b1;
            settle();
            check("conflict_addr", mem_req_addr, exp_addr[i]);
        end
        for (int i = 0; i < 4; i++) begin
            step(); mem_rsp_vld = 1'b1; mem_rsp_addr = exp_addr[i]; mem_rsp_data = 32'hA000 + 32'(i);
            settle();
        end

        // Grant lock: fetch presented, unacked, while load/store raises valid
        for (int i = 0; i < 4; i++) begin
            step();
            ifu_req_vld = 1'b1; ifu_req_addr = 32'h300;
            lsu_req_vld = (i > 0); lsu_req_rnw = 1'b1; lsu_req_addr = 32'h310;
            mem_req_ack = (i == 3);
            settle();
            check("lock_addr", mem_req_addr, 32'h300);
        end
        check("lock_ifu_ack", 32'(ifu_req_ack), 32'd1);
        check("lock_lsu_ack", 32'(lsu_req_ack), 32'd0);
        step(); lsu_req_vld = 1'b1; lsu_req_rnw = 1'b1; lsu_req_addr = 32'h310; mem_req_ack = 1'b1;
        settle();
        check("after_lock_lsu_ack", 32'(lsu_req_ack), 32'd1);
        for (int i = 0; i < 2; i++) begin
            step(); mem_rsp_vld = 1'b1; mem_rsp_data = 32'hB000 + 32'(i);
            settle();
        end

        // Fill the owner FIFO with load/store reads
        for (int i = 0; i < 16; i++) begin
            step(); lsu_req_vld = 1'b1; lsu_req_rnw = 1'b1; lsu_req_addr = 32'h3000 + 32'(i * 4);
            mem_req_ack = 1'b1;
            settle();
        end
        step(); ifu_req_vld = 1'b1; ifu_req_addr = 32'h400; mem_req_ack = 1'b1;
        settle();
        check("full_read_blocked", 32'(mem_req_vld), 32'd0);
        step(); ifu_req_vld = 1'b1; ifu_req_addr = 32'h400; mem_req_ack = 1'b1;
        lsu_req_vld = 1'b1; lsu_req_rnw = 1'b0; lsu_req_addr = 32'h200; lsu_req_data = 32'hCAFE;
        settle();
        check("full_write_addr", mem_req_addr, 32'h200);
        check("full_write_rnw", 32'(mem_req_rnw), 32'd0);
        check("full_write_ack", 32'(lsu_req_ack), 32'd1);
        check("full_write_ifu_ack", 32'(ifu_req_ack), 32'd0);
        step(); ifu_req_vld = 1'b1; ifu_req_addr = 32'h400; mem_req_ack = 1'b1;
        mem_rsp_vld = 1'b1; mem_rsp_data = 32'hC000;
        settle();
        check("full_pop_still_blocked", 32'(mem_req_vld), 32'd0);
        check("full_pop_lsu_rsp", 32'(lsu_rsp_vld), 32'd1);
        step(); ifu_req_vld = 1'b1; ifu_req_addr = 32'h400; mem_req_ack = 1'b1;
        settle();
        check("unfull_read_addr", mem_req_addr, 32'h400);
        check("unfull_read_ack", 32'(ifu_req_ack), 32'd1);
        for (int i = 0; i < 16; i++) begin
            step(); mem_rsp_vld = 1'b1; mem_rsp_data = 32'hD000 + 32'(i);
            settle();
            if (i == 15) check("drain_last_ifu", 32'(ifu_rsp_vld), 32'd1);
        end

        // Count of 5, then same-cycle push and pop
        for (int i = 0; i < 5; i++) begin
            step();
            if (i % 2 == 0) begin
                ifu_req_vld = 1'b1; ifu_req_addr = 32'h500 + 32'(i);
            end else begin
                lsu_req_vld = 1'b1; lsu_req_rnw = 1'b1; lsu_req_addr = 32'h600 + 32'(i);
            end
            mem_req_ack = 1'b1;
            settle();
        end
        exp_own[0] = 1'b0; exp_own[1] = 1'b1; exp_own[2] = 1'b0;
        exp_own[3] = 1'b1; exp_own[4] = 1'b0; exp_own[5] = 1'b1;
        step(); lsu_req_vld = 1'b1; lsu_req_rnw = 1'b1; lsu_req_addr = 32'h700; mem_req_ack = 1'b1;
        mem_rsp_vld = 1'b1; mem_rsp_data = 32'hE000;
        settle();
        check("pushpop_lsu_ack", 32'(lsu_req_ack), 32'd1);
        check("pushpop_owner0", 32'(lsu_rsp_vld), 32'(exp_own[0]));
        for (int i = 1; i < 6; i++) begin
            step(); mem_rsp_vld = 1'b1; mem_rsp_data = 32'hE000 + 32'(i);
            settle();
            check("order_lsu_vld", 32'(lsu_rsp_vld), 32'(exp_own[i]));
            check("order_ifu_vld", 32'(ifu_rsp_vld), 32'(!exp_own[i]));
        end
        step(); mem_rsp_vld = 1'b1; mem_rsp_data = 32'hE0FF;
        settle();
        check("count5_extra_ifu", 32'(ifu_rsp_vld), 32'd0);
        check("count5_extra_lsu", 32'(lsu_rsp_vld), 32'd0);
        step();
        settle();
        check("count5_orphan", 32'(rsp_orphan), 32'd1);

        // Reset clears orphan; reset mid-flight discards ownership
        step(); reset = 1'b1;
        settle();
        step();
        settle();
        check("orphan_cleared", 32'(rsp_orphan), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step(); ifu_req_vld = 1'b1; ifu_req_addr = 32'h800 + 32'(i); mem_req_ack = 1'b1;
            settle();
        end
        step(); reset = 1'b1;
        settle();
        step(); mem_rsp_vld = 1'b1; mem_rsp_data = 32'hF00D;
        settle();
        check("post_rst_ifu_vld", 32'(ifu_rsp_vld), 32'd0);
        check("post_rst_lsu_vld", 32'(lsu_rsp_vld), 32'd0);
        step();
        settle();
        check("post_rst_orphan", 32'(rsp_orphan), 32'd1);

        step();
        settle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
